// File: rtl/iter_divider.sv
// iter_divider: radix-2 restoring integer divider, signed or unsigned,
// returning quotient and remainder together after WIDTH iteration cycles.
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   flush                   cancel any pending or in-flight operation
//   in_valid / in_ready     operand handshake (in_ready only in IDLE)
//   in_signed               1 = two's-complement, 0 = unsigned
//   dividend, divisor       operands, sampled only at the accept edge
//   out_valid / out_ready   result handshake (out_valid only in DONE)
//   quotient, remainder     registered results, held while out_valid
//   busy                    high in CALC and DONE
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] dvd_s, dsr_s;
  logic                    dvd_neg, dsr_neg;
  logic                    accept, div_zero, last_step;

  logic [CW-1:0]    cnt_p1;
  logic [WIDTH-1:0] dsr_p0;
  logic             q_neg_p0, r_neg_p0;
  logic [WIDTH-1:0] rem_p1, quo_p1;

  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] q_step, r_step;

  // Two's-complement negate when requested. Used both for operand magnitude
  // (|MIN| comes out as 2^(WIDTH-1) read as unsigned) and for sign fix-up.
  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                    input logic neg);
    return neg ? -v : v;
  endfunction

  assign dvd_s   = dividend;
  assign dsr_s   = divisor;
  assign dvd_neg = in_signed && (dvd_s < 0);
  assign dsr_neg = in_signed && (dsr_s < 0);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign accept    = in_valid && in_ready && !flush;
  assign div_zero  = (divisor == '0);
  assign last_step = (state == CALC) && (cnt_p1 == CW'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = div_zero ? DONE : CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Restoring step: shift in the next dividend bit (MSB first, taken from the
  // top of quo_p1 which doubles as the quotient shift register) and keep the
  // trial difference only when it did not borrow.
  always_comb begin
    shifted = {rem_p1, quo_p1[WIDTH-1]};
    diff    = shifted - {1'b0, dsr_p0};
    q_step  = {quo_p1[WIDTH-2:0], ~diff[WIDTH]};
    r_step  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  // p0: operand magnitudes and result signs latched at acceptance
  // p1: partial remainder / quotient iterate once per CALC cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      dsr_p0   <= cond_negate(divisor, dsr_neg);
      q_neg_p0 <= dvd_neg ^ dsr_neg;
      r_neg_p0 <= dvd_neg;
      rem_p1   <= '0;
      quo_p1   <= cond_negate(dividend, dvd_neg);
    end else if (state == CALC) begin
      rem_p1   <= r_step;
      quo_p1   <= q_step;
    end
  end

  // Result registers: sign fix-up happens on the way in so outputs are flops
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_p1    <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (accept) begin
        cnt_p1 <= CW'(WIDTH);
      end else if (state == CALC) begin
        cnt_p1 <= cnt_p1 - CW'(1);
      end

      if (accept && div_zero) begin
        quotient  <= '1;
        remainder <= dividend;
      end else if (last_step && !flush) begin
        quotient  <= cond_negate(q_step, q_neg_p0);
        remainder <= cond_negate(r_step, r_neg_p0);
      end
    end
  end

endmodule

// File: doc/iter_divider.md
# iter_divider

Parametrised multi-cycle integer divider for the EXE stage. It replaces the fixed 32-bit vendor divider IP pair with a single radix-2 restoring divider that handles both signed and unsigned division, and returns quotient and remainder together. Operands enter and results leave through valid/ready handshakes, so the EXE stage stalls on `out_valid` instead of tracking separate divisor/dividend ready flags. A flush input discards the in-flight operation when an exception or ertn reaches WB.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 2.
- `clk` in 1: clock; all state changes on the rising edge.
- `resetn` in 1: reset is asynchronous and active-low.
- `flush` in 1: synchronous cancel of any pending or in-flight operation.
- `in_valid` in 1: operands and mode are valid.
- `in_ready` out 1: divider can accept an operation.
- `in_signed` in 1: 1 selects two's-complement division, 0 selects unsigned division.
- `dividend` in WIDTH: dividend operand.
- `divisor` in WIDTH: divisor operand.
- `out_valid` out 1: `quotient` and `remainder` are valid.
- `out_ready` in 1: consumer takes the result.
- `quotient` out WIDTH: quotient result.
- `remainder` out WIDTH: remainder result.
- `busy` out 1: high in the CALC and DONE states.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - CALC: iterating.
  - DONE: `out_valid`=1, result held.
- IDLE → CALC on `in_valid & in_ready`:
  - Latch the magnitudes of both operands. In signed mode, the magnitude of a negative operand is its negation, treated as unsigned, so |MIN| = 2^(WIDTH-1).
  - Latch `q_neg` = `in_signed & (dividend[W-1] ^ divisor[W-1])`.
  - Latch `r_neg` = `in_signed & dividend[W-1]`.
  - Load the iteration counter with WIDTH.
- Divisor = 0 at acceptance: go IDLE → DONE directly with `quotient` = all ones and `remainder` = `dividend` (raw, unsigned and signed alike).
- CALC, one restoring step per cycle:
  - Shift the partial remainder left one bit and bring in the next dividend bit, MSB first.
  - Trial-subtract the divisor magnitude in WIDTH+1 bits.
  - If the result is non-negative, keep it and set the quotient bit to 1.
  - Decrement the counter.
- CALC → DONE when the counter reaches 0. Sign fix-up (two's-complement negate on `q_neg` / `r_neg`) is applied before the result registers are written, so the outputs are pure registers.
- Sign rules:
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Signed MIN / −1 gives `quotient` = MIN and `remainder` = 0. No trap.
- DONE → IDLE on `out_ready`. There is no accept in the same cycle; `in_ready` is 0 in DONE.
- `flush`:
  - Highest priority; any state goes to IDLE on the next edge.
  - An `in_valid` handshake in the flush cycle is ignored.
  - A result not yet consumed is discarded.
  - `out_valid` is low from the cycle after flush.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `quotient`=0, `remainder`=0, counter 0.

## Timing
- Acceptance edge at the end of cycle t. Cycles t+1 … t+WIDTH are CALC. `out_valid` first rises in cycle t+WIDTH+1 (33 cycles for WIDTH=32).
- Divide-by-zero: `out_valid` rises in cycle t+1.
- `quotient` and `remainder` stay stable while `out_valid & !out_ready`, for any number of cycles.
- `in_ready` is combinational from state only. No combinational path from `in_valid`/`out_ready` to any output.
- Back-to-back throughput: one operation per WIDTH+2 cycles (DONE consumed at the first opportunity, then IDLE accepts).
- Asynchronous `resetn` assertion mid-CALC: all outputs take their reset values immediately. First acceptance is possible in the first cycle after deassertion.
- Operand inputs are sampled only at the acceptance edge. Later changes on `dividend`/`divisor` do not affect the result.

## Test plan
All scenarios use WIDTH=32.
1. Unsigned 100 / 7 -> `quotient`=14, `remainder`=2. `out_valid` first high exactly 33 cycles after the acceptance cycle. `busy` is high throughout.
2. Signed −7 / 2 -> 0xFFFFFFFD, 0xFFFFFFFF. Signed 7 / −2 -> 0xFFFFFFFD, 0x00000001. Unsigned 0xFFFFFFF9 / 2 -> 0x7FFFFFFC, 0x00000001.
3. Divide-by-zero: 0x12345678 / 0 (signed and unsigned) -> `quotient` 0xFFFFFFFF, `remainder` 0x12345678, `out_valid` one cycle after acceptance. Signed 0x80000000 / 0xFFFFFFFF -> 0x80000000, 0.
4. Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` -> results unchanged, `in_ready`=0, new `in_valid` not accepted. Release -> IDLE next cycle.
5. Flush in the 10th CALC cycle -> `out_valid` never rises, `in_ready`=1 the next cycle. A following 9 / 3 returns 3, 0. Flush coincident with `in_valid` in IDLE -> no acceptance.
6. `resetn` pulsed low mid-CALC -> outputs reset immediately. After release, 1000 / 10 (unsigned) returns 100, 0 with the nominal 33-cycle latency.
